// File: rtl/ebi_pkg.sv
// rtl/ebi_pkg.sv - shared types and widths for the EBI bus initiator
package ebi_pkg;

    localparam int EBI_AD_W = 16;
    localparam int TIMER_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ASETUP,
        ST_ALE,
        ST_AHOLD,
        ST_STROBE,
        ST_DHOLD,
        ST_TURN
    } ebi_state_t;

    typedef struct packed {
        logic                write;
        logic [EBI_AD_W-1:0] addr;
        logic [EBI_AD_W-1:0] wdata;
    } ebi_req_t;

endpackage

// File: rtl/ebi_phase_timer.sv
// rtl/ebi_phase_timer.sv - down counter that measures the length of one bus phase
module ebi_phase_timer
    import ebi_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_value,
    output logic               o_done
);

    logic [TIMER_W-1:0] r_count;

    // load phase length minus one on state entry, then count down to zero and hold
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/ebi_master.sv
// rtl/ebi_master.sv - single-word initiator for the multiplexed 16-bit EBI bus
module ebi_master
    import ebi_pkg::*;
#(
    parameter int ADDR_SETUP   = 1,
    parameter int ALE_WIDTH    = 1,
    parameter int ADDR_HOLD    = 1,
    parameter int STROBE_WIDTH = 2,
    parameter int DATA_HOLD    = 1,
    parameter int TURNAROUND   = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [EBI_AD_W-1:0] req_addr,
    input  logic [EBI_AD_W-1:0] req_wdata,
    output logic                rsp_valid,
    output logic                rsp_write,
    output logic [EBI_AD_W-1:0] rsp_rdata,
    output logic [EBI_AD_W-1:0] EBI_AD_out,
    output logic                EBI_AD_oe,
    input  logic [EBI_AD_W-1:0] EBI_AD_in,
    output logic                EBI_ALE,
    output logic                EBI_WE,
    output logic                EBI_RE
);

    if (ADDR_SETUP < 1 || ADDR_SETUP > 15 || ALE_WIDTH < 1 || ALE_WIDTH > 15 ||
        ADDR_HOLD < 1 || ADDR_HOLD > 15 || STROBE_WIDTH < 1 || STROBE_WIDTH > 15 ||
        DATA_HOLD < 1 || DATA_HOLD > 15 || TURNAROUND < 1 || TURNAROUND > 15) begin : g_bad_param
        $error("ebi_master: every phase length must be within 1..15");
    end

    ebi_state_t          r_state;
    ebi_state_t          w_next;
    ebi_req_t            r_req;
    ebi_req_t            w_req;
    logic                w_accept;
    logic                w_done;
    logic                w_load;
    logic [TIMER_W-1:0]  w_load_val;
    logic                w_leave_strobe;
    logic                w_ready_n;
    logic                w_oe_n;
    logic [EBI_AD_W-1:0] w_ad_n;
    logic                w_ale_n;
    logic                w_we_n;
    logic                w_re_n;

    assign w_accept       = (r_state == ST_IDLE) && req_valid && req_ready;
    assign w_leave_strobe = (r_state == ST_STROBE) && w_done;
    assign w_load         = (w_next != r_state);

    ebi_phase_timer u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_load),
        .i_value (w_load_val),
        .o_done  (w_done)
    );

    // phase sequencing: each non-idle phase ends when its timer runs out
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_next = ST_ASETUP;
            ST_ASETUP: if (w_done)   w_next = ST_ALE;
            ST_ALE:    if (w_done)   w_next = ST_AHOLD;
            ST_AHOLD:  if (w_done)   w_next = ST_STROBE;
            ST_STROBE: if (w_done)   w_next = ST_DHOLD;
            ST_DHOLD:  if (w_done)   w_next = ST_TURN;
            ST_TURN:   if (w_done)   w_next = ST_IDLE;
            default:                 w_next = ST_IDLE;
        endcase
    end

    // length of the phase being entered, minus one
    always_comb begin
        w_load_val = '0;
        case (w_next)
            ST_ASETUP: w_load_val = TIMER_W'(ADDR_SETUP - 1);
            ST_ALE:    w_load_val = TIMER_W'(ALE_WIDTH - 1);
            ST_AHOLD:  w_load_val = TIMER_W'(ADDR_HOLD - 1);
            ST_STROBE: w_load_val = TIMER_W'(STROBE_WIDTH - 1);
            ST_DHOLD:  w_load_val = TIMER_W'(DATA_HOLD - 1);
            ST_TURN:   w_load_val = TIMER_W'(TURNAROUND - 1);
            default:   w_load_val = '0;
        endcase
    end

    // bus pin values for the phase being entered, so the registered pins line up with the state
    always_comb begin
        w_req     = w_accept ? {req_write, req_addr, req_wdata} : r_req;
        w_ready_n = 1'b0;
        w_oe_n    = 1'b0;
        w_ad_n    = '0;
        w_ale_n   = 1'b1;
        w_we_n    = 1'b1;
        w_re_n    = 1'b1;
        case (w_next)
            ST_IDLE: w_ready_n = 1'b1;
            ST_ASETUP, ST_AHOLD: begin
                w_oe_n = 1'b1;
                w_ad_n = w_req.addr;
            end
            ST_ALE: begin
                w_oe_n  = 1'b1;
                w_ad_n  = w_req.addr;
                w_ale_n = 1'b0;
            end
            ST_STROBE: begin
                if (w_req.write) begin
                    w_oe_n = 1'b1;
                    w_ad_n = w_req.wdata;
                    w_we_n = 1'b0;
                end else begin
                    w_re_n = 1'b0;
                end
            end
            ST_DHOLD: begin
                if (w_req.write) begin
                    w_oe_n = 1'b1;
                    w_ad_n = w_req.wdata;
                end
            end
            default: ;
        endcase
    end

    // state and latched request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_req   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) r_req <= {req_write, req_addr, req_wdata};
        end
    end

    // registered bus pins and request handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_ready  <= 1'b0;
            EBI_AD_oe  <= 1'b0;
            EBI_AD_out <= '0;
            EBI_ALE    <= 1'b1;
            EBI_WE     <= 1'b1;
            EBI_RE     <= 1'b1;
        end else begin
            req_ready  <= w_ready_n;
            EBI_AD_oe  <= w_oe_n;
            EBI_AD_out <= w_ad_n;
            EBI_ALE    <= w_ale_n;
            EBI_WE     <= w_we_n;
            EBI_RE     <= w_re_n;
        end
    end

    // completion pulse on the edge that ends the strobe; read data captured on that same edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= w_leave_strobe;
            if (w_leave_strobe) begin
                rsp_write <= r_req.write;
                if (!r_req.write) rsp_rdata <= EBI_AD_in;
            end
        end
    end

endmodule

// File: tb/tb_ebi_master.sv
// tb/tb_ebi_master.sv - self-checking bench for ebi_master (default and custom timing)
module tb_ebi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        vld[2], wr[2], rdy[2], rsp_v[2], rsp_w[2], oe[2], ale[2], we[2], re[2];
    logic [15:0] adr[2], wd[2], rdat[2], ad_out[2], ad_in[2], pad[2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rsp_cnt[2], rsp_cyc[2], acc_cyc[2], prev_acc[2];
    int ale_run[2], ale_len[2], we_run[2], we_len[2];
    logic [15:0] rsp_data[2], rx_addr[2], rx_data[2];
    logic        rsp_wr[2], prev_we[2];
    logic [31:0] rx0[$];
    logic [31:0] rx1[$];

    // pad model: the remote side drives AD only while the read strobe is low
    assign ad_in[0] = re[0] ? 16'h0000 : pad[0];
    assign ad_in[1] = re[1] ? 16'h0000 : pad[1];

    ebi_master u0 (
        .clk(clk), .reset_n(reset_n), .req_valid(vld[0]), .req_ready(rdy[0]), .req_write(wr[0]),
        .req_addr(adr[0]), .req_wdata(wd[0]), .rsp_valid(rsp_v[0]), .rsp_write(rsp_w[0]),
        .rsp_rdata(rdat[0]), .EBI_AD_out(ad_out[0]), .EBI_AD_oe(oe[0]), .EBI_AD_in(ad_in[0]),
        .EBI_ALE(ale[0]), .EBI_WE(we[0]), .EBI_RE(re[0])
    );

    ebi_master #(
        .ADDR_SETUP(3), .ALE_WIDTH(2), .ADDR_HOLD(2), .STROBE_WIDTH(4), .DATA_HOLD(2), .TURNAROUND(3)
    ) u1 (
        .clk(clk), .reset_n(reset_n), .req_valid(vld[1]), .req_ready(rdy[1]), .req_write(wr[1]),
        .req_addr(adr[1]), .req_wdata(wd[1]), .rsp_valid(rsp_v[1]), .rsp_write(rsp_w[1]),
        .rsp_rdata(rdat[1]), .EBI_AD_out(ad_out[1]), .EBI_AD_oe(oe[1]), .EBI_AD_in(ad_in[1]),
        .EBI_ALE(ale[1]), .EBI_WE(we[1]), .EBI_RE(re[1])
    );

    // bus rule checks plus a receiver model, sampled just after each falling edge
    always begin
        @(negedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            total++;
            if ((!we[i] && !re[i]) || (!ale[i] && (!we[i] || !re[i])) || (oe[i] && !re[i])) begin
                bad++;
                $display("FAIL bus_rules u%0d: ale=%b we=%b re=%b oe=%b required no overlap and no oe with re low",
                         i, ale[i], we[i], re[i], oe[i]);
            end
            if (!reset_n) begin
                prev_we[i] = 1'b1;
                ale_run[i] = 0;
                we_run[i]  = 0;
            end else begin
                if (!ale[i]) rx_addr[i] = ad_out[i];
                if (!we[i])  rx_data[i] = ad_out[i];
                if (!prev_we[i] && we[i]) begin
                    if (i == 0) rx0.push_back({rx_addr[i], rx_data[i]});
                    else        rx1.push_back({rx_addr[i], rx_data[i]});
                end
                prev_we[i] = we[i];
                if (!ale[i]) ale_run[i]++;
                else if (ale_run[i] != 0) begin ale_len[i] = ale_run[i]; ale_run[i] = 0; end
                if (!we[i]) we_run[i]++;
                else if (we_run[i] != 0) begin we_len[i] = we_run[i]; we_run[i] = 0; end
                if (rsp_v[i]) begin
                    rsp_cnt[i]++;
                    rsp_cyc[i]  = cyc;
                    rsp_data[i] = rdat[i];
                    rsp_wr[i]   = rsp_w[i];
                end
                if (vld[i] && rdy[i]) begin
                    prev_acc[i] = acc_cyc[i];
                    acc_cyc[i]  = cyc;
                end
            end
        end
    end

    task automatic xfer(input int i, input logic w, input logic [15:0] a, input logic [15:0] d);
        int n = 0;
        @(negedge clk);
        vld[i] = 1'b1; wr[i] = w; adr[i] = a; wd[i] = d;
        while (!rdy[i] && n < 100) begin @(negedge clk); n++; end
        total++;
        if (n >= 100) begin bad++; $display("FAIL accept_timeout u%0d: ready=%b required 1", i, rdy[i]); end
        @(negedge clk);
        vld[i] = 1'b0; wr[i] = 1'($urandom); adr[i] = 16'($urandom); wd[i] = 16'($urandom);
    endtask

    task automatic wait_rsp(input int i, input int target);
        int n = 0;
        while (rsp_cnt[i] < target && n < 100) begin @(negedge clk); #2; n++; end
        total++;
        if (n >= 100) begin bad++; $display("FAIL rsp_timeout u%0d: rsp count=%0d required %0d", i, rsp_cnt[i], target); end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({ale[i], we[i], re[i], oe[i], rdy[i], rsp_v[i], rsp_w[i]} !== 7'b1110000 ||
                ad_out[i] !== 16'h0 || rdat[i] !== 16'h0) begin
                bad++;
                $display("FAIL reset_values u%0d: ale/we/re/oe/rdy/rv/rw=%b%b%b%b%b%b%b ad=%h rd=%h required 1110000 0000 0000",
                         i, ale[i], we[i], re[i], oe[i], rdy[i], rsp_v[i], rsp_w[i], ad_out[i], rdat[i]);
            end
        end
        reset_n = 1'b1;
        #1;
        total++;
        if (rdy[0] !== 1'b0) begin bad++; $display("FAIL ready_before_edge: ready=%b required 0", rdy[0]); end
        @(posedge clk);
        #1;
        total++;
        if (rdy[0] !== 1'b1 || rdy[1] !== 1'b1) begin
            bad++; $display("FAIL ready_after_edge: ready=%b%b required 11", rdy[0], rdy[1]);
        end
    endtask

    task automatic test_write(input int i, input logic [15:0] a, input logic [15:0] d, input int lat);
        int c = rsp_cnt[i];
        logic [31:0] got;
        xfer(i, 1'b1, a, d);
        wait_rsp(i, c + 1);
        got = (i == 0) ? ((rx0.size() > 0) ? rx0[$] : 32'hx) : ((rx1.size() > 0) ? rx1[$] : 32'hx);
        total++;
        if (got !== {a, d}) begin bad++; $display("FAIL write_rx u%0d: addr/data=%h required %h", i, got, {a, d}); end
        total++;
        if (rsp_wr[i] !== 1'b1) begin bad++; $display("FAIL write_rsp_type u%0d: rsp_write=%b required 1", i, rsp_wr[i]); end
        total++;
        if (rsp_cyc[i] - acc_cyc[i] != lat) begin
            bad++; $display("FAIL write_latency u%0d: %0d cycles required %0d", i, rsp_cyc[i] - acc_cyc[i], lat);
        end
    endtask

    task automatic test_read(input int i, input logic [15:0] a, input logic [15:0] d, input int lat);
        int c = rsp_cnt[i];
        int q = (i == 0) ? rx0.size() : rx1.size();
        pad[i] = d;
        xfer(i, 1'b0, a, 16'($urandom));
        wait_rsp(i, c + 1);
        total++;
        if (rsp_wr[i] !== 1'b0 || rsp_data[i] !== d) begin
            bad++; $display("FAIL read_data u%0d: write=%b rdata=%h required 0 %h", i, rsp_wr[i], rsp_data[i], d);
        end
        total++;
        if (rsp_cyc[i] - acc_cyc[i] != lat) begin
            bad++; $display("FAIL read_latency u%0d: %0d cycles required %0d", i, rsp_cyc[i] - acc_cyc[i], lat);
        end
        total++;
        if (((i == 0) ? rx0.size() : rx1.size()) != q) begin
            bad++; $display("FAIL read_no_write u%0d: receiver saw a write strobe during a read", i);
        end
    endtask

    task automatic test_back_to_back(input int i, input int gap);
        int n = 0;
        int c = rsp_cnt[i];
        logic [15:0] d1 = 16'($urandom);
        logic [15:0] d2 = 16'($urandom);
        logic [31:0] e1, e2;
        @(negedge clk);
        vld[i] = 1'b1; wr[i] = 1'b1; adr[i] = 16'd15; wd[i] = d1;
        while (!rdy[i] && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        adr[i] = 16'd30; wd[i] = d2;
        n = 0;
        while (!rdy[i] && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        vld[i] = 1'b0;
        #2;
        total++;
        if (acc_cyc[i] - prev_acc[i] != gap) begin
            bad++; $display("FAIL accept_gap u%0d: %0d cycles required %0d", i, acc_cyc[i] - prev_acc[i], gap);
        end
        wait_rsp(i, c + 2);
        e1 = (i == 0) ? rx0[rx0.size() - 2] : rx1[rx1.size() - 2];
        e2 = (i == 0) ? rx0[$] : rx1[$];
        total++;
        if (e1 !== {16'd15, d1} || e2 !== {16'd30, d2}) begin
            bad++; $display("FAIL b2b_order u%0d: got %h,%h required %h,%h", i, e1, e2, {16'd15, d1}, {16'd30, d2});
        end
    endtask

    task automatic test_random;
        logic        w;
        logic [15:0] a, d;
        for (int k = 0; k < 24; k++) begin
            w = 1'($urandom_range(0, 1));
            a = 16'($urandom);
            d = 16'($urandom);
            if (w) test_write(0, a, d, 6);
            else   test_read(0, a, d, 6);
        end
    endtask

    task automatic test_params;
        test_write(1, 16'($urandom), 16'($urandom), 12);
        total++;
        if (ale_len[1] != 2) begin bad++; $display("FAIL ale_width: low %0d cycles required 2", ale_len[1]); end
        total++;
        if (we_len[1] != 4) begin bad++; $display("FAIL we_width: low %0d cycles required 4", we_len[1]); end
        test_read(1, 16'($urandom), 16'($urandom), 12);
        test_back_to_back(1, 17);
    endtask

    task automatic test_reset_mid;
        int n = 0;
        int c = rsp_cnt[0];
        int q = rx0.size();
        @(negedge clk);
        vld[0] = 1'b1; wr[0] = 1'b1; adr[0] = 16'h0077; wd[0] = 16'h1234;
        while (!rdy[0] && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        vld[0] = 1'b0;
        n = 0;
        while (we[0] && n < 50) begin @(negedge clk); n++; end
        total++;
        if (we[0] !== 1'b0) begin bad++; $display("FAIL reach_strobe: we=%b required 0", we[0]); end
        #3;
        reset_n = 1'b0;
        #1;
        total++;
        if (we[0] !== 1'b1 || oe[0] !== 1'b0 || rdy[0] !== 1'b0) begin
            bad++; $display("FAIL async_reset: we=%b oe=%b ready=%b required 1 0 0", we[0], oe[0], rdy[0]);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        total++;
        if (rdy[0] !== 1'b0) begin bad++; $display("FAIL ready_at_release: ready=%b required 0", rdy[0]); end
        @(posedge clk);
        #1;
        total++;
        if (rdy[0] !== 1'b1) begin bad++; $display("FAIL ready_after_release: ready=%b required 1", rdy[0]); end
        repeat (10) @(negedge clk);
        #2;
        total++;
        if (rsp_cnt[0] != c || rx0.size() != q) begin
            bad++; $display("FAIL dropped_request: rsp=%0d writes=%0d required %0d %0d", rsp_cnt[0], rx0.size(), c, q);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            vld[i] = 1'b0; wr[i] = 1'b0; adr[i] = '0; wd[i] = '0; pad[i] = '0;
            rsp_cnt[i] = 0; rsp_cyc[i] = 0; acc_cyc[i] = 0; prev_acc[i] = 0;
            ale_run[i] = 0; ale_len[i] = 0; we_run[i] = 0; we_len[i] = 0;
            rsp_data[i] = '0; rsp_wr[i] = 1'b0; rx_addr[i] = '0; rx_data[i] = '0; prev_we[i] = 1'b1;
        end
        reset_n = 1'b1;
        #1;
        reset_n = 1'b0;
        test_reset;
        test_write(0, 16'd5, 16'd50, 6);
        test_back_to_back(0, 8);
        test_read(0, 16'h0012, 16'hBEEF, 6);
        test_random;
        test_params;
        test_reset_mid;
        test_write(0, 16'hA5A5, 16'h5A5A, 6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
